// File: rtl/mux_scan_seq_pkg.sv
// Shared types and sizes for the 4:1 mux select sequencer.
package mux_scan_seq_pkg;

    localparam int unsigned NCH   = 4;
    localparam int unsigned SEL_W = 2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/mux_next_ch.sv
// Next enabled channel finder: the lowest set mask bit, or, when first_i is low,
// the lowest set mask bit above cur_i (no wrap-around).
module mux_next_ch
    import mux_scan_seq_pkg::*;
(
    input  logic [NCH-1:0]   mask_i,
    input  logic [SEL_W-1:0] cur_i,
    input  logic             first_i,
    output logic [SEL_W-1:0] nxt_o,
    output logic             nxt_vld_o
);

    // Scanning downwards means the last hit written is the lowest qualifying channel.
    always_comb begin
        nxt_o     = '0;
        nxt_vld_o = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask_i[i] && (first_i || (i > int'(cur_i)))) begin
                nxt_o     = SEL_W'(i);
                nxt_vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_scan_seq.sv
// Select sequencer for the downstream 4:1 mux: steps Sel through the enabled
// channels, settles DWELL cycles on each, captures F, then pulses Done.
module mux_scan_seq
    import mux_scan_seq_pkg::*;
#(
    parameter int unsigned DWELL = 2,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [NCH-1:0]   mask_i,
    input  logic             f_in_i,
    output logic [SEL_W-1:0] sel_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [NCH-1:0]   sample_o,
    output logic [NCH-1:0]   sample_vld_o
);

    generate
        if ((DWELL == 0) || (DWELL > (2 ** CNT_W))) begin : g_bad_dwell
            $error("mux_scan_seq: DWELL must be in 1..2**CNT_W");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL - 1);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [NCH-1:0]     mask_q;
    logic               in_idle_c;
    logic [NCH-1:0]     search_mask_c;
    logic [SEL_W-1:0]   nxt_ch_c;
    logic               nxt_vld_c;

    // In IDLE the live mask is searched from the bottom; mid-scan the latched mask above Sel.
    assign in_idle_c     = (state_q == S_IDLE);
    assign search_mask_c = in_idle_c ? mask_i : mask_q;

    mux_next_ch u_next_ch (
        .mask_i    (search_mask_c),
        .cur_i     (sel_o),
        .first_i   (in_idle_c),
        .nxt_o     (nxt_ch_c),
        .nxt_vld_o (nxt_vld_c)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            mask_q       <= '0;
            sel_o        <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            sample_o     <= '0;
            sample_vld_o <= '0;
        end else begin
            done_o <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        mask_q       <= mask_i;
                        sample_o     <= '0;
                        sample_vld_o <= '0;
                        if (nxt_vld_c) begin
                            sel_o   <= nxt_ch_c;
                            cnt_q   <= CNT_LOAD;
                            busy_o  <= 1'b1;
                            state_q <= S_SETTLE;
                        end else begin
                            done_o  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == '0) begin
                        state_q <= S_CAPTURE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_CAPTURE: begin
                    sample_o[sel_o]     <= f_in_i;
                    sample_vld_o[sel_o] <= 1'b1;
                    if (nxt_vld_c) begin
                        sel_o   <= nxt_ch_c;
                        cnt_q   <= CNT_LOAD;
                        state_q <= S_SETTLE;
                    end else begin
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
